cp0_reg: RTL and testbench

Coprocessor-0 register file for the dual-issue MIPS core. It sits directly downstream of the exception arbitration stage and consumes its resolved exception record: exception type, faulting PC, bad address and delay-slot flag. It also services MTC0/MFC0, samples hardware interrupts and runs the Count/Compare timer. Its Status, Cause and EPC outputs feed back into the exception arbitration stage on the next cycle.

---
 rtl/cp0_pkg.sv | 61 ++++++
 rtl/cp0_timer.sv | 43 ++++
 rtl/cp0_reg.sv | 137 +++++++++++++
 tb/tb_cp0_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, ExcCode values and bit positions.
// Also imported by the exception arbitration stage.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] EXCCODE_INT  = 5'h00;
    localparam logic [4:0] EXCCODE_ADEL = 5'h04;
    localparam logic [4:0] EXCCODE_ADES = 5'h05;
    localparam logic [4:0] EXCCODE_SYS  = 5'h08;
    localparam logic [4:0] EXCCODE_BP   = 5'h09;
    localparam logic [4:0] EXCCODE_RI   = 5'h0a;
    localparam logic [4:0] EXCCODE_OV   = 5'h0c;

    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int STATUS_BEV = 22;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_TI   = 30;
    localparam int CAUSE_IP7  = 15;

    typedef struct packed {
        logic       take;
        logic       eret;
        logic       load_bad;
        logic [4:0] code;
    } exc_decode_t;

    // Unknown nonzero codes decode to all-zero, i.e. they are ignored.
    function automatic exc_decode_t decode_exc(input logic [31:0] excepttype);
        exc_decode_t d;
        d = '0;
        case (excepttype)
            EXC_INT:  begin d.take = 1'b1; d.code = EXCCODE_INT; end
            EXC_ADEL: begin d.take = 1'b1; d.code = EXCCODE_ADEL; d.load_bad = 1'b1; end
            EXC_ADES: begin d.take = 1'b1; d.code = EXCCODE_ADES; d.load_bad = 1'b1; end
            EXC_SYS:  begin d.take = 1'b1; d.code = EXCCODE_SYS; end
            EXC_BP:   begin d.take = 1'b1; d.code = EXCCODE_BP; end
            EXC_RI:   begin d.take = 1'b1; d.code = EXCCODE_RI; end
            EXC_OV:   begin d.take = 1'b1; d.code = EXCCODE_OV; end
            EXC_ERET: d.eret = 1'b1;
            default:  d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second clock, sticky timer interrupt on Count == Compare.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic tick;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tick    <= 1'b0;
            count   <= '0;
            compare <= '0;
        end else begin
            tick <= ~tick;
            if (we && waddr == CP0_COUNT)
                count <= wdata;
            else if (tick)
                count <= count + 32'd1;
            if (we && waddr == CP0_COMPARE)
                compare <= wdata;
        end
    end

    // A write to Compare acknowledges the interrupt and takes priority over a new match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            timer_int <= 1'b0;
        else if (we && waddr == CP0_COMPARE)
            timer_int <= 1'b0;
        else if (count == compare)
            timer_int <= 1'b1;
    end

endmodule

// File: rtl/cp0_reg.sv
// Coprocessor-0 register file: Status/Cause/EPC/BadVAddr, MTC0/MFC0 and exception entry/ERET.
// Define CP0_TIMER_EN to build the Count/Compare timer; otherwise Count/Compare read 0.
module cp0_reg
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] except_inst_addr_i,
    input  logic [31:0] except_bad_addr_i,
    input  logic        except_in_delayslot_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    exc_decode_t exc;
    logic        mtc0;
    logic [7:0]  status_im;
    logic        status_exl;
    logic        status_ie;
    logic        cause_bd;
    logic        cause_ti;
    logic [5:0]  cause_ip_hw;
    logic [1:0]  cause_ip_sw;
    logic [4:0]  cause_exc_code;
    logic [31:0] epc_q;
    logic [31:0] badvaddr_q;
    logic        timer_int;
    logic [31:0] count_val;
    logic [31:0] compare_val;

    assign exc  = decode_exc(excepttype_i);
    // Any exception or ERET in the same cycle swallows the MTC0 completely.
    assign mtc0 = we_i & ~(exc.take | exc.eret);

`ifdef CP0_TIMER_EN
    cp0_timer u_timer (
        .clk       (clk),
        .resetn    (resetn),
        .we        (mtc0),
        .waddr     (waddr_i),
        .wdata     (wdata_i),
        .count     (count_val),
        .compare   (compare_val),
        .timer_int (timer_int)
    );
`else
    assign count_val   = '0;
    assign compare_val = '0;
    assign timer_int   = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            status_im  <= '0;
            status_exl <= 1'b0;
            status_ie  <= 1'b0;
        end else if (exc.take) begin
            status_exl <= 1'b1;
        end else if (exc.eret) begin
            status_exl <= 1'b0;
        end else if (mtc0 && waddr_i == CP0_STATUS) begin
            status_im  <= wdata_i[15:8];
            status_exl <= wdata_i[STATUS_EXL];
            status_ie  <= wdata_i[STATUS_IE];
        end
    end

    // Hardware interrupt and timer bits are resampled every cycle regardless of exceptions.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cause_bd       <= 1'b0;
            cause_ti       <= 1'b0;
            cause_ip_hw    <= '0;
            cause_ip_sw    <= '0;
            cause_exc_code <= '0;
        end else begin
            cause_ip_hw <= {int_i[5] | timer_int, int_i[4:0]};
            cause_ti    <= timer_int;
            if (exc.take) begin
                cause_exc_code <= exc.code;
                if (!status_exl)
                    cause_bd <= except_in_delayslot_i;
            end else if (mtc0 && waddr_i == CP0_CAUSE) begin
                cause_ip_sw <= wdata_i[9:8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            if (exc.take && !status_exl)
                epc_q <= except_in_delayslot_i ? except_inst_addr_i - 32'd4 : except_inst_addr_i;
            else if (mtc0 && waddr_i == CP0_EPC)
                epc_q <= wdata_i;
            if (exc.take && exc.load_bad)
                badvaddr_q <= except_bad_addr_i;
        end
    end

    assign status_o    = {9'b0, 1'b1, 6'b0, status_im, 6'b0, status_exl, status_ie};
    assign cause_o     = {cause_bd, cause_ti, 14'b0, cause_ip_hw, cause_ip_sw, 1'b0,
                          cause_exc_code, 2'b0};
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign count_o     = count_val;
    assign compare_o   = compare_val;
    assign timer_int_o = timer_int;

    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_BADVADDR: rdata_o = badvaddr_o;
            CP0_COUNT:    rdata_o = count_o;
            CP0_COMPARE:  rdata_o = compare_o;
            CP0_STATUS:   rdata_o = status_o;
            CP0_CAUSE:    rdata_o = cause_o;
            CP0_EPC:      rdata_o = epc_o;
            default:      rdata_o = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Directed self-checking bench for cp0_reg; expectations follow CP0_TIMER_EN when it is defined.
module tb_cp0_reg;
    import cp0_pkg::*;

`ifdef CP0_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] excepttype_i;
    logic [31:0] except_inst_addr_i;
    logic [31:0] except_bad_addr_i;
    logic        except_in_delayslot_i;
    logic [31:0] status_o, cause_o, epc_o, badvaddr_o, count_o, compare_o;
    logic        timer_int_o;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk                   (clk),
        .resetn                (resetn),
        .we_i                  (we_i),
        .waddr_i               (waddr_i),
        .wdata_i               (wdata_i),
        .raddr_i               (raddr_i),
        .rdata_o               (rdata_o),
        .int_i                 (int_i),
        .excepttype_i          (excepttype_i),
        .except_inst_addr_i    (except_inst_addr_i),
        .except_bad_addr_i     (except_bad_addr_i),
        .except_in_delayslot_i (except_in_delayslot_i),
        .status_o              (status_o),
        .cause_o               (cause_o),
        .epc_o                 (epc_o),
        .badvaddr_o            (badvaddr_o),
        .count_o               (count_o),
        .compare_o             (compare_o),
        .timer_int_o           (timer_int_o)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one request cycle, clock it in, then return the request inputs to idle.
    task automatic applyStimulus(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                 input logic [31:0] exc, input logic [31:0] pc,
                                 input logic [31:0] bad, input logic ds);
        we_i                  = we;
        waddr_i               = waddr;
        wdata_i               = wdata;
        excepttype_i          = exc;
        except_inst_addr_i    = pc;
        except_bad_addr_i     = bad;
        except_in_delayslot_i = ds;
        @(posedge clk);
        #1;
        we_i                  = 1'b0;
        excepttype_i          = '0;
        except_in_delayslot_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        resetn = 1'b0; we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; int_i = '0;
        excepttype_i = '0; except_inst_addr_i = '0; except_bad_addr_i = '0;
        except_in_delayslot_i = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        #1;
        $display("[TB] reset released");
        checkOutput("rst_status", status_o, 32'h0040_0000);
        checkOutput("rst_cause", cause_o, 32'h0);
        checkOutput("rst_epc", epc_o, 32'h0);
        checkOutput("rst_badvaddr", badvaddr_o, 32'h0);
        checkOutput("rst_count", count_o, 32'h0);
        checkOutput("rst_compare", compare_o, 32'h0);
        checkOutput("rst_timer_int", {31'b0, timer_int_o}, 32'h0);

        // Timer: Compare=5 on edge 1, Count=0 on edge 2 (tick phase 1, increment suppressed).
        applyStimulus(1'b1, CP0_COMPARE, 32'd5, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, CP0_COUNT, 32'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("compare_wr", compare_o, TIMER_EN ? 32'd5 : 32'd0);
        raddr_i = CP0_COMPARE;
        #1;
        checkOutput("rd_compare", rdata_o, TIMER_EN ? 32'd5 : 32'd0);
        idle(9);
        checkOutput("count_9cyc", count_o, TIMER_EN ? 32'd4 : 32'd0);
        idle(1);
        checkOutput("count_10cyc", count_o, TIMER_EN ? 32'd5 : 32'd0);
        checkOutput("timer_not_yet", {31'b0, timer_int_o}, 32'h0);
        idle(1);
        checkOutput("timer_set", {31'b0, timer_int_o}, {31'b0, TIMER_EN});
        checkOutput("cause_lag", cause_o, 32'h0);
        idle(1);
        checkOutput("cause_ti_ip7", cause_o, TIMER_EN ? 32'h4000_8000 : 32'h0);
        checkOutput("count_adv", count_o, TIMER_EN ? 32'd6 : 32'd0);
        applyStimulus(1'b1, CP0_COMPARE, 32'h100, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("timer_clr", {31'b0, timer_int_o}, 32'h0);
        checkOutput("compare_100", compare_o, TIMER_EN ? 32'h100 : 32'h0);
        idle(1);
        checkOutput("cause_ti_clr", cause_o, 32'h0);
        // Count wrap: load on an edge with tick phase 0, next edge increments.
        applyStimulus(1'b1, CP0_COUNT, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("count_load", count_o, TIMER_EN ? 32'hFFFF_FFFF : 32'h0);
        idle(1);
        checkOutput("count_wrap", count_o, 32'h0);

        int_i = 6'b100001;
        idle(1);
        checkOutput("cause_hw_int", cause_o, 32'h0000_8400);
        int_i = 6'b000000;
        idle(1);
        checkOutput("cause_hw_clr", cause_o, 32'h0);

        applyStimulus(1'b1, CP0_CAUSE, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("cause_sw_wr", cause_o, 32'h0000_0300);
        raddr_i = CP0_CAUSE;
        #1;
        checkOutput("rd_cause", rdata_o, 32'h0000_0300);
        applyStimulus(1'b1, CP0_CAUSE, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b1, CP0_STATUS, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("status_wr", status_o, 32'h0040_FF03);
        raddr_i = CP0_STATUS;
        #1;
        checkOutput("rd_status", rdata_o, 32'h0040_FF03);
        applyStimulus(1'b1, CP0_STATUS, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("status_wr0", status_o, 32'h0040_0000);
        applyStimulus(1'b1, CP0_EPC, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 1'b0);
        raddr_i = CP0_EPC;
        #1;
        checkOutput("rd_epc", rdata_o, 32'h1234_5678);
        applyStimulus(1'b1, CP0_BADVADDR, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("badvaddr_ro", badvaddr_o, 32'h0);
        applyStimulus(1'b1, 5'd5, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 1'b0);
        raddr_i = 5'd5;
        #1;
        checkOutput("rd_unmapped", rdata_o, 32'h0);

        $display("[TB] exception sequence");
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ADEL, 32'hBFC0_0100, 32'hBFC0_0101, 1'b0);
        checkOutput("adel_epc", epc_o, 32'hBFC0_0100);
        checkOutput("adel_bad", badvaddr_o, 32'hBFC0_0101);
        checkOutput("adel_cause", cause_o, 32'h0000_0010);
        checkOutput("adel_status", status_o, 32'h0040_0002);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ERET, 32'h0, 32'h0, 1'b0);
        checkOutput("eret1_status", status_o, 32'h0040_0000);
        checkOutput("eret1_epc", epc_o, 32'hBFC0_0100);

        applyStimulus(1'b0, 5'd0, 32'h0, EXC_SYS, 32'h8000_0008, 32'h0, 1'b1);
        checkOutput("sys_ds_epc", epc_o, 32'h8000_0004);
        checkOutput("sys_ds_cause", cause_o, 32'h8000_0020);
        checkOutput("sys_bad_kept", badvaddr_o, 32'hBFC0_0101);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ERET, 32'h0, 32'h0, 1'b0);
        checkOutput("eret2_status", status_o, 32'h0040_0000);
        checkOutput("eret2_epc", epc_o, 32'h8000_0004);
        checkOutput("eret2_cause", cause_o, 32'h8000_0020);

        applyStimulus(1'b0, 5'd0, 32'h0, EXC_RI, 32'h8000_0010, 32'h0, 1'b0);
        checkOutput("ri_epc", epc_o, 32'h8000_0010);
        checkOutput("ri_cause", cause_o, 32'h0000_0028);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_OV, 32'h8000_0020, 32'h0, 1'b1);
        checkOutput("nested_epc", epc_o, 32'h8000_0010);
        checkOutput("nested_cause", cause_o, 32'h0000_0030);
        checkOutput("nested_status", status_o, 32'h0040_0002);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ERET, 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b1, CP0_STATUS, 32'h0000_FF01, EXC_BP, 32'h8000_0040, 32'h0, 1'b0);
        checkOutput("clash_status", status_o, 32'h0040_0002);
        checkOutput("clash_cause", cause_o, 32'h0000_0024);
        checkOutput("clash_epc", epc_o, 32'h8000_0040);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ERET, 32'h0, 32'h0, 1'b0);

        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ADES, 32'h8000_0060, 32'h1234_5670, 1'b0);
        checkOutput("ades_bad", badvaddr_o, 32'h1234_5670);
        checkOutput("ades_cause", cause_o, 32'h0000_0014);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_ERET, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 5'd0, 32'h0, 32'h0000_0003, 32'h0000_AAAA, 32'h0, 1'b1);
        checkOutput("ignored_epc", epc_o, 32'h8000_0060);
        checkOutput("ignored_status", status_o, 32'h0040_0000);
        checkOutput("ignored_cause", cause_o, 32'h0000_0014);
        applyStimulus(1'b0, 5'd0, 32'h0, EXC_INT, 32'h8000_0070, 32'h0, 1'b0);
        checkOutput("int_cause", cause_o, 32'h0000_0000);
        checkOutput("int_epc", epc_o, 32'h8000_0070);

        @(negedge clk);
        resetn = 1'b0;
        #1;
        checkOutput("async_status", status_o, 32'h0040_0000);
        checkOutput("async_epc", epc_o, 32'h0);
        checkOutput("async_bad", badvaddr_o, 32'h0);
        checkOutput("async_count", count_o, 32'h0);
        idle(1);
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
